mips32_mem_arbiter: RTL and testbench
=====================================

// Module: mips32_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous word memory between three masters of the mips32 core:
//  instruction fetch (IF), data load/store (D, MEM stage) and a program loader/debug port (LD).
//  Per-master req/ack handshake, fixed priority LD > D > IF, and a starvation guard for IF.
//  The pipeline stalls on a missing ack. Sits between the core and the Mem array.
// PARAMETERS
//  ADDR_W      10  word-address width (1024 words)
//  DATA_W      32  data word width
//  STARVE_MAX  4   consecutive D grants with IF waiting before IF is forced through (>=1)
// PORTS
//  clk        in   1       single system clock, all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       IF read request; held with if_addr until if_ack
//  if_addr    in   ADDR_W  IF word address
//  if_ack     out  1       one-cycle pulse; if_rdata valid this cycle
//  if_rdata   out  DATA_W  fetched word
//  d_req      in   1       data request; d_we/d_addr/d_wdata held until d_ack
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       one-cycle pulse; d_rdata valid this cycle (loads)
//  d_rdata    out  DATA_W  load data
//  ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata: loader port, same rules as the D port
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable (qualified by mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid the cycle after mem_en
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  FSM IDLE -> GRANT -> RESP -> IDLE. One access per 3 cycles; ack arrives 2 cycles after the
//   first cycle in which req is seen in IDLE.
//  IDLE: if any req is set, latch the winner id, we, addr and wdata, then go to GRANT. Else stay.
//  GRANT: mem_en=1 plus the latched we/addr/wdata for exactly one cycle, then go to RESP.
//  RESP: ack of the latched master = 1 and its rdata = mem_rdata (writes also return mem_rdata,
//   which is don't-care), then go to IDLE. All other acks stay 0.
//  Priority at IDLE: ld_req > d_req > if_req, except that IF wins over D when starve_cnt ==
//   STARVE_MAX and if_req=1. LD always wins; it is used only while the core is halted.
//  starve_cnt: +1 on each D grant while if_req=1, saturating at STARVE_MAX. Cleared on an IF
//   grant, or in any IDLE cycle with if_req=0.
//  rdata outputs are registered and hold their last value when not acked. Only the acked
//   master's rdata updates.
//  A req dropped before its ack is a protocol violation. The latched access still completes
//   and the ack still pulses.
//  Addresses are taken as ADDR_W bits; there is no range check.
//  rst, including mid-access: next state IDLE; all acks, mem_en, mem_we and busy = 0; rdata
//   outputs = 0; starve_cnt = 0; latched fields = 0. A write already driven in GRANT is not
//   undone. No ack is issued for an access cut short by reset.
//  rst has priority over every other event in the same cycle.
// STRUCTURE
//  Shared package mips32_pkg: requester ids REQ_IF=2'd0, REQ_D=2'd1, REQ_LD=2'd2; arbiter
//   state encodings S_IDLE/S_GRANT/S_RESP; the memory ADDR_W/DATA_W defaults used by the core.
//  One sub-module: mips32_mem_prio_sel. It is combinational and takes the three reqs plus
//   starve_cnt==STARVE_MAX, and outputs a winner id and a valid flag.
//  FSM, latches, starvation counter and ack/rdata registers stay in mips32_mem_arbiter.
// TESTING
//  Setup: Behavioural 1-cycle RAM; preload Mem[200]=32'h0000000A, Mem[0]=32'h280A00C8.
//  1. if_req, addr 0, alone -> mem_en in cycle 2; if_ack in cycle 3 with if_rdata=32'h280A00C8;
//     busy for exactly 2 cycles.
//  2. d_req store addr 198 wdata 32'h14, then d_req load 198 -> second d_ack returns 32'h14;
//     mem_we=1 only in the store GRANT cycle.
//  3. if_req and d_req in the same cycle (load 200) -> d_ack first with 32'h0A; if_ack one
//     access (3 cycles) later.
//  4. if_req held and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,...
//     No IF wait is longer than 4 D accesses.
//  5. ld_req with d_req and if_req all set -> LD is served first for every ld_req beat until
//     it drops.
//  6. rst pulsed during GRANT of a d store to 50 -> no d_ack; busy=0 and all outputs at reset
//     values next cycle; Mem[50] may be written; a re-issued request completes normally.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 core memory subsystem.
package mips32_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 32;

  localparam logic [1:0] REQ_IF = 2'd0;
  localparam logic [1:0] REQ_D  = 2'd1;
  localparam logic [1:0] REQ_LD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mips32_mem_prio_sel.sv
// Fixed-priority requester select: LD > D > IF, with IF promoted over D once starved.
module mips32_mem_prio_sel
  import mips32_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       ld_req,
  input  logic       if_starved,
  output logic [1:0] winner,
  output logic       valid
);

  // Pick the highest-priority active requester.
  always_comb begin
    winner = REQ_IF;
    valid  = if_req | d_req | ld_req;
    if (ld_req) begin
      winner = REQ_LD;
    end else if (if_req && if_starved) begin
      winner = REQ_IF;
    end else if (d_req) begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Three-master arbiter (IF, D, LD) in front of one single-port synchronous word memory.
// One access every 3 cycles: IDLE (latch winner) -> GRANT (drive memory) -> RESP (ack).
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state;
  logic [1:0]        lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_full;

  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] d_hold;
  logic [DATA_W-1:0] ld_hold;

  logic [1:0]        win_id;
  logic              win_valid;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

  mips32_mem_prio_sel u_prio_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .ld_req     (ld_req),
    .if_starved (starve_full),
    .winner     (win_id),
    .valid      (win_valid)
  );

  // Route the winning master's access fields to the latch inputs.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = if_addr;
    win_wdata = '0;
    case (win_id)
      REQ_LD: begin
        win_we    = ld_we;
        win_addr  = ld_addr;
        win_wdata = ld_wdata;
      end
      REQ_D: begin
        win_we    = d_we;
        win_addr  = d_addr;
        win_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Latched access fields drive the memory bus directly.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // Memory data arrives in the ack cycle, so it bypasses the hold register then;
  // the hold register keeps the word visible until that master's next ack.
  assign if_rdata = if_ack ? mem_rdata : if_hold;
  assign d_rdata  = d_ack  ? mem_rdata : d_hold;
  assign ld_rdata = ld_ack ? mem_rdata : ld_hold;

  // Arbiter FSM, access latches, starvation counter, ack and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_id     <= REQ_IF;
      mem_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      busy       <= 1'b0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      ld_ack     <= 1'b0;
      if_hold    <= '0;
      d_hold     <= '0;
      ld_hold    <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      ld_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!if_req) begin
            starve_cnt <= '0;
          end
          if (win_valid) begin
            lat_id    <= win_id;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            busy      <= 1'b1;
            state     <= S_GRANT;
            if (win_id == REQ_IF) begin
              starve_cnt <= '0;
            end else if (win_id == REQ_D && if_req && !starve_full) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        S_GRANT: begin
          state <= S_RESP;
          case (lat_id)
            REQ_LD:  ld_ack <= 1'b1;
            REQ_D:   d_ack  <= 1'b1;
            default: if_ack <= 1'b1;
          endcase
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          case (lat_id)
            REQ_LD:  ld_hold <= mem_rdata;
            REQ_D:   d_hold  <= mem_rdata;
            default: if_hold <= mem_rdata;
          endcase
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: drivers issue directed accesses, a negedge
// monitor checks ack order/data against queued expectations and timed probes.
module tb_mips32_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  localparam int P_MEM_EN   = 0;
  localparam int P_MEM_WE   = 1;
  localparam int P_BUSY     = 2;
  localparam int P_IF_ACK   = 3;
  localparam int P_D_ACK    = 4;
  localparam int P_LD_ACK   = 5;
  localparam int P_IF_RDATA = 6;
  localparam int P_D_RDATA  = 7;
  localparam int P_LD_RDATA = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    int            cyc;
    int            sig;
    logic [DW-1:0] val;
  } probe_t;

  typedef struct packed {
    logic          chk;
    logic [DW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          ld_req = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  logic [DW-1:0] mem [1024];

  int     cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;
  int     exp_order [$];
  exp_t   exp_if [$];
  exp_t   exp_d [$];
  exp_t   exp_ld [$];
  probe_t probe_q [$];

  req_t s_if [8];
  req_t s_d [8];
  req_t s_ld [8];

  mips32_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM, read-before-write, one cycle latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  function automatic logic [DW-1:0] probe_val(input int sig);
    case (sig)
      P_MEM_EN:   return {31'b0, mem_en};
      P_MEM_WE:   return {31'b0, mem_we};
      P_BUSY:     return {31'b0, busy};
      P_IF_ACK:   return {31'b0, if_ack};
      P_D_ACK:    return {31'b0, d_ack};
      P_LD_ACK:   return {31'b0, ld_ack};
      P_IF_RDATA: return if_rdata;
      P_D_RDATA:  return d_rdata;
      default:    return ld_rdata;
    endcase
  endfunction

  function automatic string probe_name(input int sig);
    case (sig)
      P_MEM_EN:   return "mem_en";
      P_MEM_WE:   return "mem_we";
      P_BUSY:     return "busy";
      P_IF_ACK:   return "if_ack";
      P_D_ACK:    return "d_ack";
      P_LD_ACK:   return "ld_ack";
      P_IF_RDATA: return "if_rdata";
      P_D_RDATA:  return "d_rdata";
      default:    return "ld_rdata";
    endcase
  endfunction

  // Monitor: timed probes and ack scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    int     n_ack;
    int     act_id;
    int     eid;
    exp_t   e;
    logic   have_e;
    logic [DW-1:0] act_data;
    logic [DW-1:0] act;
    probe_t p;

    for (int i = probe_q.size() - 1; i >= 0; i--) begin
      if (probe_q[i].cyc <= cyc) begin
        p = probe_q[i];
        probe_q.delete(i);
        act = probe_val(p.sig);
        n_vec++;
        if (p.cyc != cyc || act !== p.val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", probe_name(p.sig), p.cyc, act, p.val);
        end
      end
    end

    n_ack = int'(if_ack) + int'(d_ack) + int'(ld_ack);
    if (!rst && n_ack != 0) begin
      act_id   = ld_ack ? 2 : (d_ack ? 1 : 0);
      act_data = ld_ack ? ld_rdata : (d_ack ? d_rdata : if_rdata);
      n_vec++;
      if (exp_order.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack @cyc %0d: got ack id %0d want no ack", cyc, act_id);
      end else begin
        eid = exp_order.pop_front();
        if (eid != act_id || n_ack != 1) begin
          n_bad++;
          $display("FAIL grant_order @cyc %0d: got id %0d (%0d acks) want id %0d", cyc, act_id, n_ack, eid);
        end
      end
      have_e = 1'b0;
      e      = '0;
      case (act_id)
        0: if (exp_if.size() > 0) begin e = exp_if.pop_front(); have_e = 1'b1; end
        1: if (exp_d.size() > 0)  begin e = exp_d.pop_front();  have_e = 1'b1; end
        default: if (exp_ld.size() > 0) begin e = exp_ld.pop_front(); have_e = 1'b1; end
      endcase
      if (have_e && e.chk) begin
        n_vec++;
        if (act_data !== e.val) begin
          n_bad++;
          $display("FAIL rdata id %0d @cyc %0d: got %h want %h", act_id, cyc, act_data, e.val);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input int c, input int sig, input logic [DW-1:0] v);
    probe_t p;
    p.cyc = c;
    p.sig = sig;
    p.val = v;
    probe_q.push_back(p);
  endtask

  task automatic push_exp(input int m, input logic chk, input logic [DW-1:0] v);
    exp_t e;
    e.chk = chk;
    e.val = v;
    exp_order.push_back(m);
    case (m)
      0: exp_if.push_back(e);
      1: exp_d.push_back(e);
      default: exp_ld.push_back(e);
    endcase
  endtask

  task automatic set_port(input int m, input logic req, input req_t r);
    case (m)
      0: begin
        if_req  = req;
        if_addr = r.addr;
      end
      1: begin
        d_req   = req;
        d_we    = r.we;
        d_addr  = r.addr;
        d_wdata = r.wdata;
      end
      default: begin
        ld_req   = req;
        ld_we    = r.we;
        ld_addr  = r.addr;
        ld_wdata = r.wdata;
      end
    endcase
  endtask

  function automatic logic port_ack(input int m);
    case (m)
      0: return if_ack;
      1: return d_ack;
      default: return ld_ack;
    endcase
  endfunction

  // Issue n back-to-back accesses on one port, holding req until each ack.
  task automatic run_port(input int m, input req_t seq [8], input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      set_port(m, 1'b1, seq[i]);
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!port_ack(m) && w < 60);
      if (!port_ack(m)) begin
        $display("FAIL ack_timeout port %0d beat %0d: got no ack in %0d cycles want ack", m, i, w);
        $fatal(1, "ack timeout");
      end
    end
    set_port(m, 1'b0, '0);
  endtask

  function automatic req_t mk(input logic we, input int addr, input logic [DW-1:0] wd);
    req_t r;
    r.we    = we;
    r.addr  = AW'(addr);
    r.wdata = wd;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[200] = 32'h0000000A;
    mem[0]   = 32'h280A00C8;

    // Reset state.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    c = cyc;
    probe(c, P_BUSY, 0);
    probe(c, P_MEM_EN, 0);
    probe(c, P_IF_RDATA, 0);
    probe(c, P_D_ACK, 0);
    idle(2);

    // 1: lone IF fetch of address 0.
    c = cyc;
    probe(c,     P_BUSY, 0);
    probe(c + 1, P_MEM_EN, 1);
    probe(c + 1, P_MEM_WE, 0);
    probe(c + 1, P_BUSY, 1);
    probe(c + 2, P_MEM_EN, 0);
    probe(c + 2, P_IF_ACK, 1);
    probe(c + 2, P_BUSY, 1);
    probe(c + 3, P_BUSY, 0);
    probe(c + 3, P_IF_ACK, 0);
    probe(c + 3, P_IF_RDATA, 32'h280A00C8);
    probe(c + 3, P_D_RDATA, 0);
    push_exp(0, 1'b1, 32'h280A00C8);
    s_if[0] = mk(1'b0, 0, '0);
    run_port(0, s_if, 1);
    idle(2);

    // 2: D store 198 then load 198.
    c = cyc;
    probe(c + 1, P_MEM_WE, 1);
    probe(c + 4, P_MEM_EN, 1);
    probe(c + 4, P_MEM_WE, 0);
    push_exp(1, 1'b0, '0);
    push_exp(1, 1'b1, 32'h00000014);
    s_d[0] = mk(1'b1, 198, 32'h14);
    s_d[1] = mk(1'b0, 198, '0);
    run_port(1, s_d, 2);
    idle(2);

    // 3: IF and D load 200 together; D first, IF one access later.
    c = cyc;
    probe(c + 2, P_D_ACK, 1);
    probe(c + 2, P_IF_ACK, 0);
    probe(c + 5, P_IF_ACK, 1);
    push_exp(1, 1'b1, 32'h0000000A);
    push_exp(0, 1'b1, 32'h280A00C8);
    s_if[0] = mk(1'b0, 0, '0);
    s_d[0]  = mk(1'b0, 200, '0);
    fork
      run_port(0, s_if, 1);
      run_port(1, s_d, 1);
    join
    idle(2);

    // 4: IF and D both held; IF forced through after 4 D grants.
    s_d[0] = mk(1'b0, 200, '0);
    s_d[1] = mk(1'b0, 198, '0);
    s_d[2] = mk(1'b0, 200, '0);
    s_d[3] = mk(1'b0, 198, '0);
    s_d[4] = mk(1'b0, 200, '0);
    s_d[5] = mk(1'b0, 198, '0);
    s_if[0] = mk(1'b0, 0, '0);
    s_if[1] = mk(1'b0, 200, '0);
    push_exp(1, 1'b1, 32'h0000000A);
    push_exp(1, 1'b1, 32'h00000014);
    push_exp(1, 1'b1, 32'h0000000A);
    push_exp(1, 1'b1, 32'h00000014);
    push_exp(0, 1'b1, 32'h280A00C8);
    push_exp(1, 1'b1, 32'h0000000A);
    push_exp(1, 1'b1, 32'h00000014);
    push_exp(0, 1'b1, 32'h0000000A);
    fork
      run_port(0, s_if, 2);
      run_port(1, s_d, 6);
    join
    idle(2);

    // 5: LD beats win over pending D and IF.
    s_ld[0] = mk(1'b1, 300, 32'h55);
    s_ld[1] = mk(1'b0, 300, '0);
    s_d[0]  = mk(1'b0, 200, '0);
    s_if[0] = mk(1'b0, 0, '0);
    push_exp(2, 1'b0, '0);
    push_exp(2, 1'b1, 32'h00000055);
    push_exp(1, 1'b1, 32'h0000000A);
    push_exp(0, 1'b1, 32'h280A00C8);
    fork
      run_port(0, s_if, 1);
      run_port(1, s_d, 1);
      run_port(2, s_ld, 2);
    join
    idle(2);

    // 6: reset during GRANT of a D store to 50, then re-issue.
    c = cyc;
    probe(c + 1, P_MEM_EN, 1);
    probe(c + 2, P_BUSY, 0);
    probe(c + 2, P_MEM_EN, 0);
    probe(c + 2, P_MEM_WE, 0);
    probe(c + 2, P_D_ACK, 0);
    probe(c + 2, P_D_RDATA, 0);
    probe(c + 2, P_IF_RDATA, 0);
    probe(c + 2, P_LD_RDATA, 0);
    probe(c + 3, P_D_ACK, 0);
    set_port(1, 1'b1, mk(1'b1, 50, 32'hDEAD));
    idle(1);
    rst = 1'b1;
    set_port(1, 1'b0, '0);
    idle(1);
    rst = 1'b0;
    idle(2);
    push_exp(1, 1'b0, '0);
    push_exp(1, 1'b1, 32'h00000077);
    s_d[0] = mk(1'b1, 50, 32'h77);
    s_d[1] = mk(1'b0, 50, '0);
    run_port(1, s_d, 2);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
